// File: rtl/st_dio_pkg.sv
// Shared types and constants for the Atari ST HPS data-I/O DMA endpoint.
package st_dio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_READ     = 2'd2,
      ST_WAIT_ACK = 2'd3
   } dio_state_e;

   localparam logic [3:0] IDX_CTRL    = 4'd0;
   localparam logic [3:0] IDX_ADDR_H  = 4'd1;
   localparam logic [3:0] IDX_ADDR_M  = 4'd2;
   localparam logic [3:0] IDX_ADDR_L  = 4'd3;
   localparam logic [3:0] IDX_WORDS_H = 4'd4;
   localparam logic [3:0] IDX_WORDS_L = 4'd5;
   localparam logic [3:0] IDX_LEVEL   = 4'd6;
   localparam logic [3:0] IDX_RESULT  = 4'd7;

   localparam logic [7:0] NAK_RESULT = 8'hFF;

   // A programmed count of zero stands for a full 64K-word transfer.
   function automatic logic [16:0] word_count(input logic [15:0] words);
      return (words == 16'd0) ? 17'h1_0000 : {1'b0, words};
   endfunction

endpackage

// File: rtl/st_dio_fifo.sv
// Synchronous show-ahead FIFO: head word is visible without a read strobe,
// reads as zero when empty. Push when full and pop when empty are ignored.
module st_dio_fifo #(
   parameter int FIFO_AW = 4,
   parameter int DATA_W  = 16
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               i_clr,
   input  logic               i_push,
   input  logic [DATA_W-1:0]  i_wdata,
   input  logic               i_pop,
   output logic [DATA_W-1:0]  o_head,
   output logic               o_full,
   output logic               o_empty,
   output logic [FIFO_AW:0]   o_level
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_level;
   logic               w_push;
   logic               w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = r_level[FIFO_AW];
   assign o_empty = (r_level == {(FIFO_AW+1){1'b0}});
   assign o_level = r_level;
   assign o_head  = o_empty ? {DATA_W{1'b0}} : r_mem[r_rptr];

   // Storage array, written at the tail.
   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointers and fill level; clear takes priority over traffic.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= {FIFO_AW{1'b0}};
         r_rptr  <= {FIFO_AW{1'b0}};
         r_level <= {(FIFO_AW+1){1'b0}};
      end else if (i_clr) begin
         r_wptr  <= {FIFO_AW{1'b0}};
         r_rptr  <= {FIFO_AW{1'b0}};
         r_level <= {(FIFO_AW+1){1'b0}};
      end else begin
         if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
            2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/st_dio_dma.sv
// Core-side endpoint of the ST HPS data-I/O link: moves toggle-strobed words
// between the HPS stream and ST RAM through a FIFO and a single-outstanding RAM port.
module st_dio_dma
   import st_dio_pkg::*;
#(
   parameter int FIFO_AW = 4,
   parameter int ADDR_W  = 23
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dio_in_strobe,
   input  logic [15:0]       dio_in,
   input  logic              dio_out_strobe,
   output logic [15:0]       dio_out,
   input  logic              dma_ack,
   input  logic [7:0]        dma_status,
   input  logic              dma_nak,
   output logic [7:0]        dio_status,
   input  logic [3:0]        dio_status_idx,
   input  logic              dma_start,
   input  logic              dma_dir,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [15:0]       dma_words,
   output logic              dma_busy,
   output logic              dma_done,
   output logic [7:0]        dma_result,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata,
   input  logic              ram_ack
);

   logic              r_armed;
   logic              r_prev_in, r_prev_out, r_prev_ack, r_prev_nak;
   logic              r_ev_in, r_ev_out, r_ev_ack, r_ev_nak;
   logic [15:0]       r_din;
   logic [7:0]        r_stat_in;
   dio_state_e        r_state, w_next;
   logic              r_dir;
   logic [ADDR_W-1:0] r_addr;
   logic [16:0]       r_words;
   logic [16:0]       r_left;
   logic              r_overrun, r_underrun;
   logic              r_req, r_we;
   logic [15:0]       r_wdata;
   logic              r_end_pend;
   logic [7:0]        r_end_res;
   logic              r_done, r_busy;
   logic [7:0]        r_result;

   logic              w_full, w_empty;
   logic [FIFO_AW:0]  w_level;
   logic [15:0]       w_head, w_fifo_wdata;
   logic              w_fifo_push, w_fifo_pop;
   logic              w_start, w_active, w_end_ev, w_ending, w_finish, w_ack_seen;
   logic [7:0]        w_ev_res, w_fin_res, w_status;
   logic              w_wr_push, w_wr_pop, w_rd_push, w_rd_pop;
   logic              w_issue_wr, w_issue_rd, w_overrun_ev, w_underrun_ev;
   logic [23:0]       w_addr24;

   st_dio_fifo #(.FIFO_AW(FIFO_AW), .DATA_W(16)) u_fifo (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .i_clr   (w_start),
      .i_push  (w_fifo_push),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_fifo_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Toggle detectors; the first cycle after reset only primes the prev registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_armed    <= 1'b0;
         r_prev_in  <= 1'b0;
         r_prev_out <= 1'b0;
         r_prev_ack <= 1'b0;
         r_prev_nak <= 1'b0;
         r_ev_in    <= 1'b0;
         r_ev_out   <= 1'b0;
         r_ev_ack   <= 1'b0;
         r_ev_nak   <= 1'b0;
         r_din      <= 16'h0000;
         r_stat_in  <= 8'h00;
      end else begin
         r_armed    <= 1'b1;
         r_prev_in  <= dio_in_strobe;
         r_prev_out <= dio_out_strobe;
         r_prev_ack <= dma_ack;
         r_prev_nak <= dma_nak;
         r_ev_in    <= r_armed & (dio_in_strobe ^ r_prev_in);
         r_ev_out   <= r_armed & (dio_out_strobe ^ r_prev_out);
         r_ev_ack   <= r_armed & (dma_ack ^ r_prev_ack);
         r_ev_nak   <= r_armed & (dma_nak ^ r_prev_nak);
         r_din      <= dio_in;
         r_stat_in  <= dma_status;
      end
   end

   // Transfer control strobes derived from state, events and FIFO flags.
   always_comb begin
      w_start    = (r_state == ST_IDLE) & dma_start;
      w_active   = (r_state == ST_WRITE) | (r_state == ST_READ);
      w_end_ev   = r_ev_ack | r_ev_nak;
      w_ev_res   = r_ev_nak ? NAK_RESULT : r_stat_in;
      // Once an ack/nak is seen mid-transfer, only the outstanding request may finish.
      w_ending   = w_active & (w_end_ev | r_end_pend);
      w_ack_seen = r_req & ram_ack;
      w_finish   = ((r_state == ST_WAIT_ACK) & w_end_ev) | (w_ending & (~r_req | ram_ack));
      w_fin_res  = r_end_pend ? r_end_res : w_ev_res;
      w_wr_push  = r_ev_in & (r_state == ST_WRITE) & ~w_full & (r_left != 17'd0);
      w_wr_pop   = (r_state == ST_WRITE) & w_ack_seen;
      w_issue_wr = (r_state == ST_WRITE) & ~w_empty & ~r_req & ~w_ending & (r_words != 17'd0);
      w_issue_rd = (r_state == ST_READ) & ~w_full & ~r_req & ~w_ending & (r_left != 17'd0);
      w_rd_push  = (r_state == ST_READ) & w_ack_seen & ~w_ending;
      w_rd_pop   = r_ev_out & (r_state == ST_READ) & ~w_empty;
      w_overrun_ev  = r_ev_in & (r_state != ST_IDLE) & ~r_dir & ~w_wr_push;
      w_underrun_ev = r_ev_out & (r_state != ST_IDLE) & r_dir & ~w_rd_pop;
      w_fifo_push  = w_wr_push | w_rd_push;
      w_fifo_pop   = w_wr_pop | w_rd_pop;
      w_fifo_wdata = r_dir ? ram_rdata : r_din;
   end

   // FSM state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (dma_start) w_next = dma_dir ? ST_READ : ST_WRITE;
            else           w_next = ST_IDLE;
         end
         ST_WRITE: begin
            if (w_finish)                  w_next = ST_IDLE;
            else if (r_words == 17'd0)     w_next = ST_WAIT_ACK;
            else                           w_next = ST_WRITE;
         end
         ST_READ: begin
            if (w_finish)                                       w_next = ST_IDLE;
            else if ((r_left == 17'd0) & ~r_req & w_empty)      w_next = ST_WAIT_ACK;
            else                                                w_next = ST_READ;
         end
         ST_WAIT_ACK: begin
            if (w_finish) w_next = ST_IDLE;
            else          w_next = ST_WAIT_ACK;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM output logic: status window.
   always_comb begin
      w_addr24 = 24'(r_addr);
      w_status = 8'h00;
      case (dio_status_idx)
         IDX_CTRL:    w_status = {r_busy, r_dir, r_overrun, r_underrun, 2'b00, 2'(r_state)};
         IDX_ADDR_H:  w_status = w_addr24[23:16];
         IDX_ADDR_M:  w_status = w_addr24[15:8];
         IDX_ADDR_L:  w_status = w_addr24[7:0];
         IDX_WORDS_H: w_status = r_words[15:8];
         IDX_WORDS_L: w_status = r_words[7:0];
         IDX_LEVEL:   w_status = 8'(w_level);
         IDX_RESULT:  w_status = r_result;
         default:     w_status = 8'h00;
      endcase
   end

   // Transfer datapath: address, counters, RAM request and error flags.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_dir      <= 1'b0;
         r_addr     <= {ADDR_W{1'b0}};
         r_words    <= 17'd0;
         r_left     <= 17'd0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= 16'h0000;
         r_end_pend <= 1'b0;
         r_end_res  <= 8'h00;
      end else if (w_start) begin
         r_dir      <= dma_dir;
         r_addr     <= dma_addr;
         r_words    <= word_count(dma_words);
         r_left     <= word_count(dma_words);
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_end_pend <= 1'b0;
      end else begin
         if (w_ack_seen) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= r_addr + ADDR_W'(1);
         end else if (w_issue_wr | w_issue_rd) begin
            r_req   <= 1'b1;
            r_we    <= w_issue_wr;
            r_wdata <= w_head;
         end
         // r_words counts words still owed to RAM (write) or to the HPS (read).
         if (w_wr_pop | w_rd_pop)    r_words <= r_words - 17'd1;
         if (w_wr_push | w_issue_rd) r_left  <= r_left - 17'd1;
         if (w_overrun_ev)  r_overrun  <= 1'b1;
         if (w_underrun_ev) r_underrun <= 1'b1;
         if (w_finish) begin
            r_end_pend <= 1'b0;
         end else if (w_active & w_end_ev & ~r_end_pend) begin
            r_end_pend <= 1'b1;
            r_end_res  <= w_ev_res;
         end
      end
   end

   // Completion outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_result <= 8'h00;
      end else begin
         r_done <= w_finish;
         r_busy <= (w_next != ST_IDLE);
         if (w_finish) r_result <= w_fin_res;
      end
   end

   assign dio_out    = w_head;
   assign dio_status = w_status;
   assign dma_busy   = r_busy;
   assign dma_done   = r_done;
   assign dma_result = r_result;
   assign ram_req    = r_req;
   assign ram_we     = r_we;
   assign ram_addr   = r_addr;
   assign ram_wdata  = r_wdata;

endmodule

// File: tb/tb_st_dio_dma.sv
// Directed bench for st_dio_dma: status-window vector table plus hand-written
// transfer sequences against a one-cycle RAM responder with a stall control.
module tb_st_dio_dma;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        dio_in_strobe = 1'b0;
   logic [15:0] dio_in = 16'h0000;
   logic        dio_out_strobe = 1'b0;
   logic [15:0] dio_out;
   logic        dma_ack = 1'b0;
   logic [7:0]  dma_status = 8'h00;
   logic        dma_nak = 1'b0;
   logic [7:0]  dio_status;
   logic [3:0]  dio_status_idx = 4'd0;
   logic        dma_start = 1'b0;
   logic        dma_dir = 1'b0;
   logic [22:0] dma_addr = 23'd0;
   logic [15:0] dma_words = 16'd0;
   logic        dma_busy, dma_done;
   logic [7:0]  dma_result;
   logic        ram_req, ram_we;
   logic [22:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata = 16'h0000;
   logic        ram_ack = 1'b0;

   logic        stall = 1'b0;
   int          log_n = 0;
   logic [22:0] log_addr [64];
   logic [15:0] log_data [64];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   int          max_level = 0;

   typedef struct {
      logic [3:0] idx;
      logic [7:0] exp;
   } stat_vec_t;
   stat_vec_t tbl [16];

   st_dio_dma #(.FIFO_AW(4), .ADDR_W(23)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .dio_in_strobe(dio_in_strobe), .dio_in(dio_in),
      .dio_out_strobe(dio_out_strobe), .dio_out(dio_out),
      .dma_ack(dma_ack), .dma_status(dma_status), .dma_nak(dma_nak),
      .dio_status(dio_status), .dio_status_idx(dio_status_idx),
      .dma_start(dma_start), .dma_dir(dma_dir), .dma_addr(dma_addr), .dma_words(dma_words),
      .dma_busy(dma_busy), .dma_done(dma_done), .dma_result(dma_result),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM responder: acks one cycle after seeing a request, read data = address.
   always @(negedge clk_sys) begin
      if (ram_ack) begin
         ram_ack = 1'b0;
      end else if (reset_n && ram_req && !stall) begin
         ram_ack   = 1'b1;
         ram_rdata = ram_addr[15:0];
         if (ram_we && log_n < 64) begin
            log_addr[log_n] = ram_addr;
            log_data[log_n] = ram_wdata;
            log_n++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_sys);
         if (mon_en) begin
            dio_status_idx = 4'd6;
            #1;
            if (int'(dio_status) > max_level) max_level = int'(dio_status);
         end
      end
   endtask

   task automatic chk_stat(input string nm, input logic [3:0] idx, input logic [7:0] exp);
      dio_status_idx = idx;
      #1;
      chk(nm, dio_status, exp);
   endtask

   task automatic start(input logic dir, input logic [22:0] addr, input logic [15:0] words);
      dma_start = 1'b1; dma_dir = dir; dma_addr = addr; dma_words = words;
      @(negedge clk_sys);
      dma_start = 1'b0;
   endtask

   task automatic tog_in(input logic [15:0] d);
      dio_in = d; dio_in_strobe = ~dio_in_strobe; tick(3);
   endtask

   task automatic tog_out();
      dio_out_strobe = ~dio_out_strobe; tick(4);
   endtask

   task automatic tog_ack(input logic [7:0] st);
      dma_status = st; dma_ack = ~dma_ack;
   endtask

   task automatic wait_stat0(input string nm, input logic [7:0] exp, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick(1);
         dio_status_idx = 4'd0;
         #1;
         if (dio_status == exp) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: status0 0x%0h, expected 0x%0h within %0d cycles", nm, dio_status, exp, budget);
      end
   endtask

   task automatic wait_done(input string nm, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk_sys);
         if (dma_done) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: no dma_done within %0d cycles", nm, budget);
      end else begin
         chk({nm, "_busy_low"}, dma_busy, 1'b0);
         @(negedge clk_sys);
         chk({nm, "_done_1cyc"}, dma_done, 1'b0);
      end
   endtask

   initial begin
      bit seen_done;
      tbl[0] = '{4'd0, 8'hC2};
      tbl[1] = '{4'd1, 8'h12};
      tbl[2] = '{4'd2, 8'h34};
      tbl[3] = '{4'd3, 8'h56};
      tbl[4] = '{4'd4, 8'h02};
      tbl[5] = '{4'd5, 8'h00};
      tbl[6] = '{4'd6, 8'h00};
      tbl[7] = '{4'd7, 8'h00};
      for (int i = 8; i < 16; i++) tbl[i] = '{4'(i), 8'h00};

      // Reset state
      tick(2);
      chk("rst_busy", dma_busy, 1'b0);
      chk("rst_done", dma_done, 1'b0);
      chk("rst_result", dma_result, 8'h00);
      chk("rst_req", ram_req, 1'b0);
      chk("rst_dio_out", dio_out, 16'h0000);
      chk_stat("rst_stat0", 4'd0, 8'h00);
      reset_n = 1'b1;
      tick(2);

      // Status window with a stalled read, then nak with a request outstanding
      stall = 1'b1;
      start(1'b1, 23'h123456, 16'h0200);
      tick(4);
      chk("st_req", ram_req, 1'b1);
      chk("st_we", ram_we, 1'b0);
      chk("st_addr", ram_addr, 23'h123456);
      for (int i = 0; i < 16; i++) begin
         dio_status_idx = tbl[i].idx;
         #1;
         checks++;
         if (dio_status !== tbl[i].exp) begin
            errors++;
            $display("FAIL status_idx%0d: got 0x%0h, expected 0x%0h", tbl[i].idx, dio_status, tbl[i].exp);
         end
      end
      dma_nak = ~dma_nak;
      tick(6);
      chk("nak_busy_held", dma_busy, 1'b1);
      chk("nak_req_held", ram_req, 1'b1);
      chk("nak_result_pending", dma_result, 8'h00);
      stall = 1'b0;
      wait_done("nak", 20);
      chk("nak_result", dma_result, 8'hFF);
      chk("nak_req_low", ram_req, 1'b0);
      chk("nak_dio_out", dio_out, 16'h0000);

      // Write 4 words from 0x100
      log_n = 0;
      start(1'b0, 23'h000100, 16'd4);
      for (int i = 0; i < 4; i++) tog_in(16'h1234 + 16'(i));
      wait_stat0("wr4_wait_ack", 8'h83, 40);
      chk("wr4_count", log_n, 4);
      for (int i = 0; i < 4; i++) begin
         chk("wr4_addr", log_addr[i], 23'h100 + 23'(i));
         chk("wr4_data", log_data[i], 16'h1234 + 16'(i));
      end
      chk_stat("wr4_addr_m", 4'd2, 8'h01);
      chk_stat("wr4_addr_l", 4'd3, 8'h04);
      tog_ack(8'h00);
      wait_done("wr4", 20);
      chk("wr4_result", dma_result, 8'h00);

      // Address wrap at the top of RAM
      log_n = 0;
      start(1'b0, 23'h7FFFFF, 16'd2);
      tog_in(16'hC0DE);
      tog_in(16'hBEEF);
      wait_stat0("wrap_wait_ack", 8'h83, 40);
      chk("wrap_count", log_n, 2);
      chk("wrap_addr0", log_addr[0], 23'h7FFFFF);
      chk("wrap_addr1", log_addr[1], 23'h000000);
      chk("wrap_data1", log_data[1], 16'hBEEF);
      tog_ack(8'h3C);
      wait_done("wrap", 20);
      chk("wrap_result", dma_result, 8'h3C);

      // Read 20 words; RAM returns address as data
      start(1'b1, 23'h000000, 16'd20);
      max_level = 0;
      mon_en = 1'b1;
      tick(80);
      chk("rd_full_level", dio_status, 8'h10);
      chk("rd_full_no_req", ram_req, 1'b0);
      for (int i = 0; i < 20; i++) begin
         chk("rd_data", dio_out, 16'(i));
         tog_out();
         tick(2);
      end
      mon_en = 1'b0;
      chk("rd_max_level", max_level, 16);
      wait_stat0("rd_wait_ack", 8'hC3, 20);
      dio_out_strobe = ~dio_out_strobe;
      tick(4);
      chk_stat("rd_underrun", 4'd0, 8'hD3);
      tog_ack(8'h5A);
      wait_done("rd", 20);
      chk("rd_result", dma_result, 8'h5A);

      // Write with RAM stalled: 17 words, one dropped
      stall = 1'b1;
      log_n = 0;
      start(1'b0, 23'h000200, 16'd32);
      for (int i = 0; i < 17; i++) tog_in(16'h5000 + 16'(i));
      chk_stat("ovr_level", 4'd6, 8'h10);
      chk_stat("ovr_stat0", 4'd0, 8'hA1);
      start(1'b1, 23'h7FFFFF, 16'd5);
      tick(2);
      chk_stat("busy_start_ignored", 4'd0, 8'hA1);
      chk_stat("busy_start_addr", 4'd3, 8'h00);
      dma_nak = ~dma_nak;
      tick(4);
      stall = 1'b0;
      wait_done("ovr_nak", 20);
      chk("ovr_result", dma_result, 8'hFF);
      chk("ovr_log_n", log_n, 1);
      chk("ovr_log_data", log_data[0], 16'h5000);

      // Reset in the middle of a write
      stall = 1'b1;
      start(1'b0, 23'h000300, 16'd4);
      tog_in(16'h7777);
      tick(2);
      chk("mid_req_before", ram_req, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_req", ram_req, 1'b0);
      chk("mid_busy", dma_busy, 1'b0);
      chk("mid_done", dma_done, 1'b0);
      chk("mid_result", dma_result, 8'h00);
      tick(2);
      reset_n = 1'b1;
      stall = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (dma_done) seen_done = 1'b1;
      end
      chk("mid_no_done", seen_done, 1'b0);
      log_n = 0;
      start(1'b0, 23'h000300, 16'd2);
      tog_in(16'hAAAA);
      tog_in(16'hBBBB);
      wait_stat0("mid_wait_ack", 8'h83, 40);
      chk("mid_log_n", log_n, 2);
      chk("mid_addr0", log_addr[0], 23'h300);
      chk("mid_data0", log_data[0], 16'hAAAA);
      chk("mid_data1", log_data[1], 16'hBBBB);
      tog_ack(8'h11);
      wait_done("mid", 20);
      chk("mid_result_after", dma_result, 8'h11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
